jstk_spi_master: RTL

JSTK_SPI_MASTER -- requirements
Module: jstk_spi_master

---
 rtl/jstk_spi_master.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/jstk_spi_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jstk_spi_master: SPI mode-0 master running one 5-byte joystick exchange. Rev 1.0
// ---------------------------------------------------------------------------
module jstk_spi_master #(
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 10
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        SNDREC,
    input  logic [39:0] DIN,
    input  logic        MISO,
    output logic        SS,
    output logic        SCLK,
    output logic        MOSI,
    output logic        BUSY,
    output logic        DONE,
    output logic [39:0] DOUT,
    output logic [9:0]  XPOS,
    output logic [9:0]  YPOS,
    output logic [2:0]  BTN
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SHIFT  = 3'd2,
        GAP    = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

    state_t      state;
    logic [39:0] tx_sr;
    logic [38:0] rx_sr;
    logic [39:0] tx_next;
    logic [39:0] rx_next;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic        phase;
    logic [15:0] cyc_cnt;

    // rx_next is the full 40-bit word once the last MISO bit has been sampled
    assign tx_next = {tx_sr[38:0], 1'b0};
    assign rx_next = {rx_sr, MISO};

    always_ff @(posedge DCLK) begin
        if (RST) begin
            state    <= IDLE;
            SS       <= 1'b1;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            DOUT     <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            phase    <= 1'b0;
            cyc_cnt  <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    SS   <= 1'b1;
                    SCLK <= 1'b0;
                    MOSI <= 1'b0;
                    BUSY <= 1'b0;
                    if (SNDREC) begin
                        tx_sr    <= DIN;
                        rx_sr    <= '0;
                        SS       <= 1'b0;
                        BUSY     <= 1'b1;
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        phase    <= 1'b0;
                        cyc_cnt  <= '0;
                        // A zero-length setup goes straight into the first bit
                        if (SETUP_CYC == 0) begin
                            state <= SHIFT;
                            MOSI  <= DIN[39];
                        end else begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cyc_cnt == SETUP_LAST) begin
                        state   <= SHIFT;
                        MOSI    <= tx_sr[39];
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (!phase) begin
                        SCLK  <= 1'b1;
                        phase <= 1'b1;
                    end else begin
                        SCLK  <= 1'b0;
                        phase <= 1'b0;
                        rx_sr <= rx_next[38:0];
                        tx_sr <= tx_next;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (byte_cnt == 3'd4) begin
                                state <= FINISH;
                                SS    <= 1'b1;
                                MOSI  <= 1'b0;
                                DONE  <= 1'b1;
                                DOUT  <= rx_next;
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
                                MOSI     <= tx_next[39];
                                if (GAP_CYC != 0) begin
                                    state   <= GAP;
                                    cyc_cnt <= '0;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            MOSI    <= tx_next[39];
                        end
                    end
                end
                GAP: begin
                    if (cyc_cnt == GAP_LAST) begin
                        state   <= SHIFT;
                        MOSI    <= tx_sr[39];
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign XPOS = {DOUT[25:24], DOUT[39:32]};
    assign YPOS = {DOUT[9:8], DOUT[23:16]};
    assign BTN  = DOUT[2:0];

endmodule
`default_nettype wire
